// File: rtl/snake_head_tracker_pkg.sv
// Shared snake definitions: heading encoding, reversal helper and grid defaults
// that the renderer also uses.
package snake_head_tracker_pkg;

  localparam int SNAKE_GRID_W = 32;
  localparam int SNAKE_GRID_H = 24;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Heading that would reverse the snake onto its own neck.
  function automatic dir_t opposite_dir(input dir_t d);
    dir_t o;
    case (d)
      DIR_UP:   o = DIR_DOWN;
      DIR_DOWN: o = DIR_UP;
      DIR_LEFT: o = DIR_RIGHT;
      default:  o = DIR_LEFT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snake_head_tracker_move_tick_divider.sv
// Game tick generator: counts 0..TICK_DIV-1 while enabled and pulses o_tick
// during the final count. Disabling holds the count where it is.
module move_tick_divider #(
  parameter int TICK_DIV = 5000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_BITS = $clog2(TICK_DIV);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(TICK_DIV - 1);

  logic [CNT_BITS-1:0] r_cnt;
  logic                w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_tick    = i_enable && w_at_last;

  // Tick counter: advances only when enabled, wraps after the last count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_head_tracker.sv
// Snake head tracker: commits heading, moves the head with toroidal wrap on each
// game tick, keeps the body history and length, and flags self-collision.
module snake_head_tracker
  import snake_head_tracker_pkg::*;
#(
  parameter int GRID_W   = SNAKE_GRID_W,
  parameter int GRID_H   = SNAKE_GRID_H,
  parameter int X_BITS   = 5,
  parameter int Y_BITS   = 5,
  parameter int MAX_LEN  = 16,
  parameter int LEN_BITS = 5,
  parameter int TICK_DIV = 5000000,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                U,
  input  logic                D,
  input  logic                L,
  input  logic                R,
  input  logic                grow,
  input  logic                pause,
  input  logic [LEN_BITS-1:0] seg_idx,
  output logic [X_BITS-1:0]   head_x,
  output logic [Y_BITS-1:0]   head_y,
  output logic [LEN_BITS-1:0] length,
  output logic                move_strobe,
  output logic                collide,
  output logic [X_BITS-1:0]   seg_x,
  output logic [Y_BITS-1:0]   seg_y,
  output logic                seg_valid
);

  localparam int unsigned BODY_N = MAX_LEN - 1;

  dir_t                r_dir;
  dir_t                r_pend;
  logic [X_BITS-1:0]   r_head_x;
  logic [Y_BITS-1:0]   r_head_y;
  logic [X_BITS-1:0]   r_body_x [BODY_N];
  logic [Y_BITS-1:0]   r_body_y [BODY_N];
  logic [LEN_BITS-1:0] r_len;
  logic                r_grow_pend;
  logic                r_strobe;
  logic                r_collide;

  logic                w_enable;
  logic                w_tick;
  logic                w_req_valid;
  dir_t                w_cand;
  logic [X_BITS-1:0]   w_next_x;
  logic [Y_BITS-1:0]   w_next_y;
  logic                w_grow_eff;
  logic [LEN_BITS-1:0] w_next_len;
  logic                w_hit;
  logic [X_BITS-1:0]   w_seg_x;
  logic [Y_BITS-1:0]   w_seg_y;

  assign w_enable = !pause && !r_collide;

  move_tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_enable (w_enable),
    .o_tick   (w_tick)
  );

  // Direction request decode: only a single asserted request is a candidate.
  always_comb begin
    w_req_valid = $onehot({U, D, L, R});
    w_cand      = DIR_RIGHT;
    if (U)      w_cand = DIR_UP;
    else if (D) w_cand = DIR_DOWN;
    else if (L) w_cand = DIR_LEFT;
  end

  // Next head position along the pending heading, wrapping at grid edges.
  always_comb begin
    w_next_x = r_head_x;
    w_next_y = r_head_y;
    case (r_pend)
      DIR_UP:    w_next_y = (r_head_y == '0) ? Y_BITS'(GRID_H - 1) : r_head_y - 1'b1;
      DIR_DOWN:  w_next_y = (r_head_y == Y_BITS'(GRID_H - 1)) ? '0 : r_head_y + 1'b1;
      DIR_LEFT:  w_next_x = (r_head_x == '0) ? X_BITS'(GRID_W - 1) : r_head_x - 1'b1;
      default:   w_next_x = (r_head_x == X_BITS'(GRID_W - 1)) ? '0 : r_head_x + 1'b1;
    endcase
  end

  // Length after the move: a grow request (sticky or this cycle) adds one, saturating.
  always_comb begin
    w_grow_eff = r_grow_pend | grow;
    w_next_len = r_len;
    if (w_grow_eff && (r_len < LEN_BITS'(MAX_LEN))) begin
      w_next_len = r_len + 1'b1;
    end
  end

  // Self-collision against the post-move body: slot 0 is the old head, slot i is
  // old body[i-1]; only slots below new_length-1 are occupied, so a vacated tail is free.
  always_comb begin
    w_hit = (w_next_x == r_head_x) && (w_next_y == r_head_y);
    for (int unsigned i = 1; i < BODY_N; i++) begin
      if ((LEN_BITS'(i + 2) <= w_next_len) &&
          (r_body_x[i-1] == w_next_x) && (r_body_y[i-1] == w_next_y)) begin
        w_hit = 1'b1;
      end
    end
  end

  // Heading: accept non-reversing requests into pending, commit pending on a move.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dir  <= DIR_RIGHT;
      r_pend <= DIR_RIGHT;
    end else begin
      if (w_req_valid && (w_cand != opposite_dir(r_dir))) begin
        r_pend <= w_cand;
      end
      if (w_tick) begin
        r_dir <= r_pend;
      end
    end
  end

  // Head, length, grow request, collision flag and move strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head_x    <= X_BITS'(START_X);
      r_head_y    <= Y_BITS'(START_Y);
      r_len       <= LEN_BITS'(3);
      r_grow_pend <= 1'b0;
      r_strobe    <= 1'b0;
      r_collide   <= 1'b0;
    end else begin
      r_strobe <= w_tick;
      if (w_tick) begin
        r_head_x    <= w_next_x;
        r_head_y    <= w_next_y;
        r_len       <= w_next_len;
        r_grow_pend <= 1'b0;
        if (w_hit) begin
          r_collide <= 1'b1;
        end
      end else if (grow) begin
        r_grow_pend <= 1'b1;
      end
    end
  end

  // Body history: shift one slot per move, old head enters slot 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < BODY_N; i++) begin
        r_body_x[i] <= '0;
        r_body_y[i] <= '0;
      end
      r_body_x[0] <= X_BITS'(START_X - 1);
      r_body_y[0] <= Y_BITS'(START_Y);
      r_body_x[1] <= X_BITS'(START_X - 2);
      r_body_y[1] <= Y_BITS'(START_Y);
    end else if (w_tick) begin
      r_body_x[0] <= r_head_x;
      r_body_y[0] <= r_head_y;
      for (int unsigned i = 1; i < BODY_N; i++) begin
        r_body_x[i] <= r_body_x[i-1];
        r_body_y[i] <= r_body_y[i-1];
      end
    end
  end

  // Segment read port for the renderer; out-of-range selects read as zero.
  always_comb begin
    w_seg_x = '0;
    w_seg_y = '0;
    for (int unsigned i = 0; i < BODY_N; i++) begin
      if (seg_idx == LEN_BITS'(i)) begin
        w_seg_x = r_body_x[i];
        w_seg_y = r_body_y[i];
      end
    end
  end

  assign head_x      = r_head_x;
  assign head_y      = r_head_y;
  assign length      = r_len;
  assign move_strobe = r_strobe;
  assign collide     = r_collide;
  assign seg_x       = w_seg_x;
  assign seg_y       = w_seg_y;
  assign seg_valid   = (seg_idx < (r_len - 1'b1));

endmodule

// File: tb/tb_snake_head_tracker.sv
// Testbench for snake_head_tracker: directed scenarios with literal expectations
// plus randomized stimulus checked every cycle against a behavioural model.
module tb_snake_head_tracker;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int ML = 16;
  localparam int TD = 4;
  localparam int SX = 16;
  localparam int SY = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       U = 1'b0, D = 1'b0, L = 1'b0, R = 1'b0;
  logic       grow = 1'b0;
  logic       pause = 1'b0;
  logic [4:0] seg_idx = '0;
  logic [4:0] head_x, head_y, length, seg_x, seg_y;
  logic       move_strobe, collide, seg_valid;

  int checks = 0;
  int errors = 0;

  snake_head_tracker #(
    .TICK_DIV(TD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .U           (U),
    .D           (D),
    .L           (L),
    .R           (R),
    .grow        (grow),
    .pause       (pause),
    .seg_idx     (seg_idx),
    .head_x      (head_x),
    .head_y      (head_y),
    .length      (length),
    .move_strobe (move_strobe),
    .collide     (collide),
    .seg_x       (seg_x),
    .seg_y       (seg_y),
    .seg_valid   (seg_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Directions: 0=up 1=down 2=left 3=right; the reverse of d is d^1.
  int dxs[4] = '{0, 0, -1, 1};
  int dys[4] = '{-1, 1, 0, 0};
  int m_dir, m_pend, m_cnt, m_len, m_hx, m_hy;
  bit m_grow, m_coll, m_strobe, m_valid = 1'b0;
  int m_bx[$];
  int m_by[$];

  task automatic model_reset();
    m_dir = 3; m_pend = 3; m_cnt = 0; m_len = 3;
    m_hx = SX; m_hy = SY;
    m_grow = 0; m_coll = 0; m_strobe = 0;
    m_bx = {}; m_by = {};
    m_bx.push_back(SX - 1); m_by.push_back(SY);
    m_bx.push_back(SX - 2); m_by.push_back(SY);
    for (int i = 2; i < ML - 1; i++) begin
      m_bx.push_back(0); m_by.push_back(0);
    end
    m_valid = 1;
  endtask

  always @(posedge clock) begin : model
    int cand, nx, ny, nl, old_pend;
    bit ge, tk, hit;
    if (reset) begin
      model_reset();
    end else if (m_valid) begin
      cand = -1;
      if ($countones({U, D, L, R}) == 1) cand = U ? 0 : D ? 1 : L ? 2 : 3;
      ge = m_grow || grow;
      tk = !pause && !m_coll && (m_cnt == TD - 1);
      old_pend = m_pend;
      if (cand >= 0 && cand != (m_dir ^ 1)) m_pend = cand;
      if (!pause && !m_coll) m_cnt = tk ? 0 : m_cnt + 1;
      m_strobe = tk;
      if (tk) begin
        nx = (m_hx + dxs[old_pend] + GW) % GW;
        ny = (m_hy + dys[old_pend] + GH) % GH;
        nl = (ge && m_len < ML) ? m_len + 1 : m_len;
        m_bx.push_front(m_hx); m_by.push_front(m_hy);
        void'(m_bx.pop_back()); void'(m_by.pop_back());
        hit = 0;
        for (int k = 0; k < nl - 1; k++)
          if (m_bx[k] == nx && m_by[k] == ny) hit = 1;
        if (hit) m_coll = 1;
        m_hx = nx; m_hy = ny; m_len = nl;
        m_dir = old_pend;
        m_grow = 0;
      end else begin
        m_grow = ge;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    int idx;
    if (m_valid) begin
      idx = int'(seg_idx);
      chk("head_x", head_x, m_hx);
      chk("head_y", head_y, m_hy);
      chk("length", length, m_len);
      chk("move_strobe", move_strobe, m_strobe);
      chk("collide", collide, m_coll);
      chk("seg_x", seg_x, (idx < ML - 1) ? m_bx[idx] : 0);
      chk("seg_y", seg_y, (idx < ML - 1) ? m_by[idx] : 0);
      chk("seg_valid", seg_valid, (idx < m_len - 1) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic pulse_dir(input int d);
    U = (d == 0); D = (d == 1); L = (d == 2); R = (d == 3);
    step(1);
    U = 0; D = 0; L = 0; R = 0;
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    step(1);
    grow = 1'b0;
  endtask

  task automatic wait_move();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!move_strobe && n < 40);
    if (!move_strobe) chk("wait_move_timeout", 0, 1);
  endtask

  task automatic chk_head(input string name, input int x, input int y);
    chk({name, "_x"}, head_x, x);
    chk({name, "_y"}, head_y, y);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    step(2);
    reset = 1'b0;
    // Reset state.
    chk_head("rst", SX, SY);
    chk("rst_len", length, 3);
    chk("rst_strobe", move_strobe, 0);
    chk("rst_collide", collide, 0);
    // First move lands four cycles after reset release.
    step(3);
    chk("pre_move_x", head_x, 16);
    chk("pre_move_strobe", move_strobe, 0);
    step(1);
    chk_head("move1", 17, 12);
    chk("move1_strobe", move_strobe, 1);
    step(1);
    chk("move1_strobe_off", move_strobe, 0);

    // Reversal rejected; U then L in one tick -> U wins.
    pulse_dir(2);
    wait_move();
    chk_head("rev_rej", 18, 12);
    pulse_dir(0);
    pulse_dir(2);
    wait_move();
    chk_head("u_then_l", 18, 11);

    // Wrap in x and y, then pause.
    do_reset();
    repeat (15) wait_move();
    chk("wrap_x_edge", head_x, 31);
    wait_move();
    chk_head("wrap_x", 0, 12);
    pulse_dir(0);
    repeat (12) wait_move();
    chk("wrap_y_edge", head_y, 0);
    wait_move();
    chk_head("wrap_y", 0, 23);
    pause = 1'b1;
    step(20);
    chk_head("pause", 0, 23);
    pause = 1'b0;

    // Growth and saturation.
    do_reset();
    pulse_grow();
    wait_move();
    chk("grow_len", length, 4);
    seg_idx = 5'd2;
    #1;
    chk("grow_tail_x", seg_x, 14);
    chk("grow_tail_y", seg_y, 12);
    chk("grow_tail_valid", seg_valid, 1);
    seg_idx = 5'd3;
    #1;
    chk("grow_past_tail_valid", seg_valid, 0);
    seg_idx = 5'd0;
    repeat (20) begin
      pulse_grow();
      wait_move();
    end
    chk("len_saturate", length, 16);

    // Length 5 loop closes on itself.
    do_reset();
    pulse_grow(); wait_move();
    pulse_grow(); wait_move();
    chk("len5", length, 5);
    pulse_dir(0); wait_move();
    pulse_dir(3); wait_move();
    pulse_dir(1); wait_move();
    pulse_dir(2); wait_move();
    chk("loop5_collide", collide, 1);
    chk_head("loop5", 18, 12);
    step(20);
    chk_head("frozen", 18, 12);
    // Reset mid-tick after growth and collision.
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_head("midrst", SX, SY);
    chk("midrst_len", length, 3);
    chk("midrst_collide", collide, 0);
    chk("midrst_strobe", move_strobe, 0);

    // Length 4 loop re-enters the vacated tail: legal.
    pulse_grow(); wait_move();
    pulse_dir(0); wait_move();
    pulse_dir(3); wait_move();
    pulse_dir(1); wait_move();
    pulse_dir(2); wait_move();
    chk("loop4_collide", collide, 0);
    chk_head("loop4", 17, 12);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      {U, D, L, R} = 4'b0000;
      if (r < 15) begin
        case ($urandom_range(0, 3))
          0: U = 1'b1;
          1: D = 1'b1;
          2: L = 1'b1;
          default: R = 1'b1;
        endcase
      end else if (r < 20) begin
        {U, D, L, R} = 4'($urandom_range(0, 15));
      end
      grow    = ($urandom_range(0, 19) == 0);
      pause   = ($urandom_range(0, 99) < 10);
      reset   = ($urandom_range(0, 299) == 0);
      seg_idx = 5'($urandom_range(0, 31));
      step(1);
    end
    {U, D, L, R} = 4'b0000;
    grow = 1'b0; pause = 1'b0; reset = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
